// File: rtl/fetch_queue.sv
// Circular fetch-bundle queue between the IFU and decode, with registered back-pressure.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned FETCH_WIDTH     = 1,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]      in_inst,
  input  logic [INST_ADDR_WIDTH-1:0]        in_pc,
  input  logic [INST_ADDR_WIDTH-1:0]        in_pc_plus_4,
  input  logic                              flush,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [FETCH_WIDTH-1:0][31:0]      out_inst,
  output logic [INST_ADDR_WIDTH-1:0]        out_pc,
  output logic [INST_ADDR_WIDTH-1:0]        out_pc_plus_4,
  output logic                              fetch_stall,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [FETCH_WIDTH-1:0][31:0]   r_inst_mem [DEPTH];
  logic [INST_ADDR_WIDTH-1:0]     r_pc_mem   [DEPTH];
  logic [INST_ADDR_WIDTH-1:0]     r_pc4_mem  [DEPTH];
  logic [PW-1:0]                  r_rd_ptr;
  logic [PW-1:0]                  r_wr_ptr;
  logic [CW-1:0]                  r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed bundle that decode takes this cycle never lands in storage.
  assign w_push = in_valid && !w_full && !flush && !(w_bypass && out_ready);
  assign w_pop  = !w_empty && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_pc4_mem[r_wr_ptr]  <= in_pc_plus_4;
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  always_comb begin
    out_valid     = !w_empty;
    out_inst      = '0;
    out_pc        = '0;
    out_pc_plus_4 = '0;
    if (!w_empty) begin
      out_inst      = r_inst_mem[r_rd_ptr];
      out_pc        = r_pc_mem[r_rd_ptr];
      out_pc_plus_4 = r_pc4_mem[r_rd_ptr];
    end else if (w_bypass) begin
      out_valid     = 1'b1;
      out_inst      = in_inst;
      out_pc        = in_pc;
      out_pc_plus_4 = in_pc_plus_4;
    end
  end

  assign fetch_stall = w_full;
  assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed literal scenarios.
module tb_fetch_queue;
  localparam int FW    = 2;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic [FW-1:0][31:0]   in_inst;
  logic [AW-1:0]         in_pc;
  logic [AW-1:0]         in_pc_plus_4;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [FW-1:0][31:0]   out_inst;
  logic [AW-1:0]         out_pc;
  logic [AW-1:0]         out_pc_plus_4;
  logic                  fetch_stall;
  logic [CW-1:0]         count;

  always #5 clk = ~clk;

  fetch_queue #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4), .fetch_stall(fetch_stall), .count(count)
  );

  typedef struct {
    logic [63:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } bundle_t;

  bundle_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] pc_seq = 32'h1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bypass_now();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (q.size() == 0) && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare();
    logic        ev;
    logic [63:0] ei;
    logic [31:0] ep, ep4;
    int n = q.size();
    ev = (n != 0);
    ei = '0; ep = '0; ep4 = '0;
    if (ev) begin
      ei = q[0].inst; ep = q[0].pc; ep4 = q[0].pc4;
    end else if (bypass_now()) begin
      ev = 1'b1; ei = in_inst; ep = in_pc; ep4 = in_pc_plus_4;
    end
    chk("count", 64'(count), 64'(n));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("fetch_stall", 64'(fetch_stall), 64'(n == DEPTH));
    if (ev) begin
      chk("out_inst", out_inst, ei);
      chk("out_pc", 64'(out_pc), 64'(ep));
      chk("out_pc_plus_4", 64'(out_pc_plus_4), 64'(ep4));
    end
  endtask

  task automatic model_update();
    bundle_t b;
    int n = q.size();
    if (flush) begin
      q.delete();
    end else if (bypass_now() && out_ready) begin
      // bundle consumed straight through; nothing stored
    end else begin
      b.inst = in_inst; b.pc = in_pc; b.pc4 = in_pc_plus_4;
      if (n != 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < DEPTH) q.push_back(b);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pcv, input logic rdy, input logic fl);
    in_valid     = v;
    in_pc        = pcv;
    in_pc_plus_4 = pcv + 32'd4;
    in_inst      = {$urandom, $urandom};
    out_ready    = rdy;
    flush        = fl;
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    in_inst = '0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_out_pc", 64'(out_pc), 64'd0);
    chk("post_rst_out_inst", out_inst, 64'd0);

    // Fill to full, then an extra bundle while stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lit_full_count", 64'(count), 64'd4);
    chk("lit_full_stall", 64'(fetch_stall), 64'd1);
    chk("lit_full_head", 64'(out_pc), 64'h0);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("lit_drain_count", 64'(count), 64'(4 - i));
      chk("lit_drain_pc", 64'(out_pc), 64'(i * 4));
      chk("lit_drain_stall", 64'(fetch_stall), 64'(i == 0));
      step();
    end
    chk("lit_drained_count", 64'(count), 64'd0);

    // Streaming through two wraps
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("lit_stream_count", 64'(count), 64'd0);
      chk("lit_stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
`else
      if (i > 0) begin
        chk("lit_stream_count", 64'(count), 64'd1);
        chk("lit_stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * (i - 1))));
      end
`endif
      step();
    end
    drain();

    // Flush beats push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    chk("lit_pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h2f0, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("lit_flush_count", 64'(count), 64'd0);
    chk("lit_flush_valid", 64'(out_valid), 64'd0);

    // Async reset between edges
    drive(1'b1, 32'h280, 1'b0, 1'b0); step();
    drive(1'b1, 32'h284, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lit_pre_rst_count", 64'(count), 64'd2);
    #1 reset = 1'b1;
    #1;
    chk("lit_async_rst_count", 64'(count), 64'd0);
    chk("lit_async_rst_valid", 64'(out_valid), 64'd0);
    #1 reset = 1'b0;
    q.delete();
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lit_first_push_count", 64'(count), 64'd1);
    chk("lit_first_push_pc", 64'(out_pc), 64'h300);
    drain();

    // Empty queue, bundle at pc 0x40 with decode ready
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("lit_bypass_valid", 64'(out_valid), 64'd1);
    chk("lit_bypass_pc", 64'(out_pc), 64'h40);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lit_bypass_count", 64'(count), 64'd0);
`else
    chk("lit_nobypass_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("lit_nobypass_next_valid", 64'(out_valid), 64'd1);
    chk("lit_nobypass_next_pc", 64'(out_pc), 64'h40);
    chk("lit_nobypass_count", 64'(count), 64'd1);
`endif
    drain();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, pc_seq, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
      pc_seq = pc_seq + 32'd4;
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
